// File: rtl/mem_access_unit_pkg.sv
// Shared memory-bus types, the memory-op descriptor and the size/alignment helpers
// used by the load/store unit and its lane-alignment datapath.
package mem_access_unit_pkg;

   typedef logic [63:0] addr_t;
   typedef logic [63:0] word_t;
   typedef logic [7:0]  strobe_t;

   typedef enum logic [2:0] {
      MSIZE1 = 3'd0,
      MSIZE2 = 3'd1,
      MSIZE4 = 3'd2,
      MSIZE8 = 3'd3
   } msize_t;

   typedef struct packed {
      logic    valid;
      addr_t   addr;
      msize_t  size;
      strobe_t strobe;
      word_t   data;
   } dbus_req_t;

   typedef struct packed {
      logic  addr_ok;
      logic  data_ok;
      word_t data;
   } dbus_resp_t;

   typedef struct packed {
      logic   is_store;
      msize_t size;
      logic   is_unsigned;
   } mem_op_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WAIT  = 2'd1,
      ST_HOLD  = 2'd2,
      ST_DRAIN = 2'd3
   } mau_state_t;

   function automatic strobe_t size_mask(input msize_t size);
      case (size)
         MSIZE1:  size_mask = 8'h01;
         MSIZE2:  size_mask = 8'h03;
         MSIZE4:  size_mask = 8'h0F;
         MSIZE8:  size_mask = 8'hFF;
         default: size_mask = 8'h00;
      endcase
   endfunction

   // Undefined size encodings are reported as misaligned so they never reach the cache.
   function automatic logic addr_aligned(input msize_t size, input logic [2:0] offset);
      case (size)
         MSIZE1:  addr_aligned = 1'b1;
         MSIZE2:  addr_aligned = (offset[0] == 1'b0);
         MSIZE4:  addr_aligned = (offset[1:0] == 2'b00);
         MSIZE8:  addr_aligned = (offset == 3'b000);
         default: addr_aligned = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane alignment: store strobe/data shift into the 64-bit bus lane and
// load data shift-down plus sign/zero extension. Shared with the uncached path.
module mem_lane_align
   import mem_access_unit_pkg::*;
(
   input  mem_op_t    op,
   input  logic [2:0] offset,
   input  word_t      wdata,
   input  word_t      rdata,
   output strobe_t    strobe,
   output word_t      wdata_lane,
   output word_t      rdata_ext
);

   logic [5:0] bit_shift;
   word_t      rdata_shift;
   logic       sext;

   assign bit_shift = {offset, 3'b000};

   // Lane shifting for both directions and extension of the selected load bytes.
   always_comb begin
      strobe      = op.is_store ? strobe_t'(size_mask(op.size) << offset) : 8'h00;
      wdata_lane  = op.is_store ? (wdata << bit_shift) : 64'h0;
      rdata_shift = rdata >> bit_shift;
      sext        = ~op.is_unsigned;
      case (op.size)
         MSIZE1:  rdata_ext = {{56{rdata_shift[7]  & sext}}, rdata_shift[7:0]};
         MSIZE2:  rdata_ext = {{48{rdata_shift[15] & sext}}, rdata_shift[15:0]};
         MSIZE4:  rdata_ext = {{32{rdata_shift[31] & sext}}, rdata_shift[31:0]};
         MSIZE8:  rdata_ext = rdata_shift;
         default: rdata_ext = rdata_shift;
      endcase
   end

endmodule

// File: rtl/mem_access_unit.sv
// Memory-stage load/store unit: issues one dbus request per op, holds it until data_ok,
// buffers results the writeback stage is not ready for, and drains requests on flush.
module mem_access_unit
   import mem_access_unit_pkg::*;
#(
   parameter bit MISALIGN_TRAP = 1'b1
)(
   input  logic       clk,
   input  logic       reset,
   input  logic       in_valid,
   input  logic       in_is_store,
   input  msize_t     in_size,
   input  logic       in_unsigned,
   input  addr_t      in_addr,
   input  word_t      in_wdata,
   input  logic       flush,
   input  logic       out_ready,
   output logic       stall,
   output logic       out_valid,
   output word_t      out_rdata,
   output logic       out_misalign,
   output dbus_req_t  dreq,
   input  dbus_resp_t dresp
);

   mau_state_t state_r, state_nx;
   dbus_req_t  req_r, issue_req_s;
   mem_op_t    op_r, in_op_s, cur_op_s;
   word_t      rdata_r, result_s, load_ext_s, wdata_lane_s;
   strobe_t    strobe_s;
   logic [2:0] cur_off_s;
   logic       trap_s, issue_s, launch_s, capture_s;
   logic       unused_s;

   assign unused_s = &{1'b0, dresp.addr_ok};

   assign in_op_s   = '{is_store: in_is_store, size: in_size, is_unsigned: in_unsigned};
   assign cur_op_s  = (state_r == ST_IDLE) ? in_op_s : op_r;
   assign cur_off_s = (state_r == ST_IDLE) ? in_addr[2:0] : req_r.addr[2:0];
   assign trap_s    = MISALIGN_TRAP && !addr_aligned(in_size, in_addr[2:0]);
   assign issue_s   = in_valid && !flush && !trap_s;
   assign launch_s  = (state_r == ST_IDLE) && issue_s && !dresp.data_ok;
   assign capture_s = dresp.data_ok && !out_ready &&
                      (((state_r == ST_IDLE) && issue_s) || ((state_r == ST_WAIT) && !flush));
   assign result_s  = cur_op_s.is_store ? 64'h0 : load_ext_s;

   mem_lane_align u_align (
      .op         (cur_op_s),
      .offset     (cur_off_s),
      .wdata      (in_wdata),
      .rdata      (dresp.data),
      .strobe     (strobe_s),
      .wdata_lane (wdata_lane_s),
      .rdata_ext  (load_ext_s)
   );

   // Request presented on the bus in the issue cycle.
   always_comb begin
      issue_req_s        = '0;
      issue_req_s.valid  = 1'b1;
      issue_req_s.addr   = in_addr;
      issue_req_s.size   = in_size;
      issue_req_s.strobe = strobe_s;
      issue_req_s.data   = wdata_lane_s;
   end

   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nx;
      end
   end

   // Outstanding request and buffered result.
   always_ff @(posedge clk) begin
      if (reset) begin
         req_r   <= '0;
         op_r    <= '0;
         rdata_r <= 64'h0;
      end else begin
         if (launch_s) begin
            req_r <= issue_req_s;
            op_r  <= in_op_s;
         end
         if (capture_s) begin
            rdata_r <= result_s;
         end
      end
   end

   // Next-state logic.
   always_comb begin
      state_nx = state_r;
      case (state_r)
         ST_IDLE: begin
            if (issue_s) begin
               if (dresp.data_ok) state_nx = out_ready ? ST_IDLE : ST_HOLD;
               else               state_nx = ST_WAIT;
            end else begin
               state_nx = ST_IDLE;
            end
         end
         ST_WAIT: begin
            if (dresp.data_ok) state_nx = (flush || out_ready) ? ST_IDLE : ST_HOLD;
            else if (flush)    state_nx = ST_DRAIN;
            else               state_nx = ST_WAIT;
         end
         ST_HOLD: begin
            if (flush || out_ready) state_nx = ST_IDLE;
            else                    state_nx = ST_HOLD;
         end
         ST_DRAIN: begin
            if (dresp.data_ok) state_nx = ST_IDLE;
            else               state_nx = ST_DRAIN;
         end
         default: state_nx = ST_IDLE;
      endcase
   end

   // Output logic; a flushed WAIT keeps the request on the bus because the cache cannot abort it.
   always_comb begin
      dreq         = '0;
      stall        = 1'b0;
      out_valid    = 1'b0;
      out_rdata    = 64'h0;
      out_misalign = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (in_valid && !flush && trap_s) begin
               out_valid    = 1'b1;
               out_misalign = 1'b1;
            end else if (issue_s) begin
               dreq      = issue_req_s;
               out_valid = dresp.data_ok;
               out_rdata = dresp.data_ok ? result_s : 64'h0;
               stall     = !dresp.data_ok;
            end else begin
               dreq = '0;
            end
         end
         ST_WAIT: begin
            dreq       = req_r;
            dreq.valid = 1'b1;
            if (flush) begin
               stall = !dresp.data_ok;
            end else if (dresp.data_ok) begin
               out_valid = 1'b1;
               out_rdata = result_s;
            end else begin
               stall = 1'b1;
            end
         end
         ST_HOLD: begin
            stall = 1'b1;
            if (flush) begin
               out_valid = 1'b0;
            end else begin
               out_valid = 1'b1;
               out_rdata = rdata_r;
            end
         end
         ST_DRAIN: begin
            dreq       = req_r;
            dreq.valid = 1'b1;
            stall      = in_valid;
         end
         default: dreq = '0;
      endcase
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: a scoreboard queue of expected results is
// filled when ops are driven and drained at every accepted out_valid.
module tb_mem_access_unit;
   import mem_access_unit_pkg::*;

   logic       clk = 1'b0;
   logic       reset, in_valid, in_is_store, in_unsigned, flush, out_ready;
   msize_t     in_size;
   addr_t      in_addr;
   word_t      in_wdata;
   logic       stall, out_valid, out_misalign;
   word_t      out_rdata;
   dbus_req_t  dreq, snap;
   dbus_resp_t dresp;

   typedef struct packed {
      word_t rdata;
      logic  mis;
   } exp_t;

   typedef struct {
      msize_t sz;
      logic   uns;
      addr_t  a;
      word_t  d;
      word_t  e;
   } ld_t;

   exp_t sb_q[$];
   exp_t sb_e;
   ld_t  ld_tab[5];
   int   n_checks = 0;
   int   n_pass   = 0;
   int   stall_cnt;

   always #5 clk = ~clk;

   mem_access_unit dut (
      .clk          (clk),
      .reset        (reset),
      .in_valid     (in_valid),
      .in_is_store  (in_is_store),
      .in_size      (in_size),
      .in_unsigned  (in_unsigned),
      .in_addr      (in_addr),
      .in_wdata     (in_wdata),
      .flush        (flush),
      .out_ready    (out_ready),
      .stall        (stall),
      .out_valid    (out_valid),
      .out_rdata    (out_rdata),
      .out_misalign (out_misalign),
      .dreq         (dreq),
      .dresp        (dresp)
   );

   task automatic check_eq(input string tag, input logic [159:0] got, input logic [159:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_op(input logic st, input msize_t sz, input logic uns,
                           input addr_t a, input word_t wd);
      in_valid    = 1'b1;
      in_is_store = st;
      in_size     = sz;
      in_unsigned = uns;
      in_addr     = a;
      in_wdata    = wd;
   endtask

   // Scoreboard: every accepted result must match the oldest expected entry.
   always @(negedge clk) begin
      if (!reset && out_valid && out_ready) begin
         if (sb_q.size() == 0) begin
            check_eq("sb_unexpected_valid", {159'd0, out_valid}, 160'd0);
         end else begin
            sb_e = sb_q.pop_front();
            check_eq("sb_rdata", out_rdata, sb_e.rdata);
            check_eq("sb_misalign", {159'd0, out_misalign}, {159'd0, sb_e.mis});
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation exceeded time budget");
      $fatal(1);
   end

   initial begin
      reset = 1'b1; in_valid = 1'b0; in_is_store = 1'b0; in_size = MSIZE1;
      in_unsigned = 1'b0; in_addr = 64'h0; in_wdata = 64'h0; flush = 1'b0;
      out_ready = 1'b1; dresp = '0;
      ld_tab[0] = '{MSIZE4, 1'b0, 64'h8000_0004, 64'h8765_4321_0000_0000, 64'hFFFF_FFFF_8765_4321};
      ld_tab[1] = '{MSIZE1, 1'b1, 64'h8000_0005, 64'h0000_F000_0000_0000, 64'h0000_0000_0000_00F0};
      ld_tab[2] = '{MSIZE1, 1'b0, 64'h8000_0005, 64'h0000_F000_0000_0000, 64'hFFFF_FFFF_FFFF_FFF0};
      ld_tab[3] = '{MSIZE2, 1'b0, 64'h8000_0006, 64'h9ABC_0000_0000_0000, 64'hFFFF_FFFF_FFFF_9ABC};
      ld_tab[4] = '{MSIZE8, 1'b1, 64'h8000_0008, 64'h8000_0000_0000_0001, 64'h8000_0000_0000_0001};

      repeat (2) tick();
      reset = 1'b0;
      #1;
      check_eq("rst_dreq_valid", {159'd0, dreq.valid}, 160'd0);
      check_eq("rst_stall", {159'd0, stall}, 160'd0);
      check_eq("rst_out_valid", {159'd0, out_valid}, 160'd0);
      check_eq("rst_out_rdata", out_rdata, 160'd0);
      check_eq("rst_out_misalign", {159'd0, out_misalign}, 160'd0);

      // Zero-latency loads: hit in the issue cycle.
      for (int i = 0; i < 5; i++) begin
         tick();
         sb_q.push_back('{rdata: ld_tab[i].e, mis: 1'b0});
         drive_op(1'b0, ld_tab[i].sz, ld_tab[i].uns, ld_tab[i].a, 64'h0);
         dresp.data_ok = 1'b1;
         dresp.data    = ld_tab[i].d;
         #1;
         check_eq("zl_dreq_valid", {159'd0, dreq.valid}, 160'd1);
         check_eq("zl_strobe", {152'd0, dreq.strobe}, 160'd0);
         check_eq("zl_addr", dreq.addr, ld_tab[i].a);
         check_eq("zl_stall", {159'd0, stall}, 160'd0);
      end

      // Zero-latency word store.
      tick();
      sb_q.push_back('{rdata: 64'h0, mis: 1'b0});
      drive_op(1'b1, MSIZE4, 1'b0, 64'h8000_0004, 64'h0000_0000_DEAD_BEEF);
      #1;
      check_eq("st4_strobe", {152'd0, dreq.strobe}, {152'd0, 8'hF0});
      check_eq("st4_data", dreq.data, {96'd0, 64'hDEAD_BEEF_0000_0000});

      // Byte store held 20 cycles, addr_ok alone in between.
      tick();
      drive_op(1'b1, MSIZE1, 1'b0, 64'h8000_0003, 64'h0000_0000_0000_00AB);
      dresp = '0;
      #1;
      check_eq("st1_strobe", {152'd0, dreq.strobe}, {152'd0, 8'h08});
      check_eq("st1_data", dreq.data, {96'd0, 64'h0000_0000_AB00_0000});
      check_eq("st1_issue_stall", {159'd0, stall}, 160'd1);
      snap = dreq;
      for (int i = 1; i <= 20; i++) begin
         tick();
         in_valid      = 1'b0;
         dresp.addr_ok = (i == 3);
         dresp.data_ok = (i == 20);
         if (i == 20) sb_q.push_back('{rdata: 64'h0, mis: 1'b0});
         #1;
         check_eq("st1_hold_req", dreq, snap);
         check_eq("st1_wait_stall", {159'd0, stall}, {159'd0, (i < 20)});
      end
      tick();
      dresp = '0;
      #1;
      check_eq("st1_released", {159'd0, dreq.valid}, 160'd0);

      // Misaligned halfword load.
      tick();
      sb_q.push_back('{rdata: 64'h0, mis: 1'b1});
      drive_op(1'b0, MSIZE2, 1'b0, 64'h8000_0001, 64'h0);
      #1;
      check_eq("mis_dreq_valid", {159'd0, dreq.valid}, 160'd0);
      check_eq("mis_flag", {159'd0, out_misalign}, 160'd1);
      check_eq("mis_out_valid", {159'd0, out_valid}, 160'd1);
      tick();
      in_valid = 1'b0;
      #1;
      check_eq("mis_no_issue", {159'd0, dreq.valid}, 160'd0);

      // Miss with writeback back-pressure into HOLD.
      tick();
      drive_op(1'b0, MSIZE8, 1'b0, 64'h8000_0010, 64'h0);
      #1;
      check_eq("miss_issue_stall", {159'd0, stall}, 160'd1);
      for (int i = 1; i <= 18; i++) begin
         tick();
         in_valid      = 1'b0;
         dresp.data_ok = (i == 18);
         dresp.data    = 64'h1122_3344_5566_7788;
         out_ready     = (i != 18);
         #1;
      end
      check_eq("miss_dok_valid", {159'd0, out_valid}, 160'd1);
      stall_cnt = 0;
      for (int j = 1; j <= 4; j++) begin
         tick();
         dresp     = '{addr_ok: 1'b0, data_ok: 1'b0, data: 64'hDEAD_0000_DEAD_0000};
         out_ready = (j == 4);
         if (j == 4) sb_q.push_back('{rdata: 64'h1122_3344_5566_7788, mis: 1'b0});
         #1;
         check_eq("hold_rdata", out_rdata, {96'd0, 64'h1122_3344_5566_7788});
         check_eq("hold_dreq_valid", {159'd0, dreq.valid}, 160'd0);
         if (stall) stall_cnt++;
      end
      check_eq("hold_stall_cycles", stall_cnt, 160'd4);
      tick();
      #1;
      check_eq("hold_done_valid", {159'd0, out_valid}, 160'd0);

      // Flush two cycles into WAIT.
      tick();
      drive_op(1'b0, MSIZE4, 1'b0, 64'h8000_0020, 64'h0);
      #1;
      tick();
      in_valid = 1'b0;
      #1;
      tick();
      flush = 1'b1;
      #1;
      check_eq("fl_req_kept", {159'd0, dreq.valid}, 160'd1);
      check_eq("fl_out_valid", {159'd0, out_valid}, 160'd0);
      tick();
      flush = 1'b0;
      #1;
      check_eq("drain_req", {159'd0, dreq.valid}, 160'd1);
      check_eq("drain_stall", {159'd0, stall}, 160'd0);
      tick();
      drive_op(1'b0, MSIZE1, 1'b1, 64'h8000_0031, 64'h0);
      #1;
      check_eq("drain_in_stall", {159'd0, stall}, 160'd1);
      check_eq("drain_addr", dreq.addr, {96'd0, 64'h8000_0020});
      tick();
      dresp.data_ok = 1'b1;
      dresp.data    = 64'h0000_0000_0000_5A00;
      #1;
      check_eq("drain_dok_valid", {159'd0, out_valid}, 160'd0);
      check_eq("drain_dok_stall", {159'd0, stall}, 160'd1);
      tick();
      sb_q.push_back('{rdata: 64'h0000_0000_0000_005A, mis: 1'b0});
      #1;
      check_eq("post_drain_addr", dreq.addr, {96'd0, 64'h8000_0031});
      check_eq("post_drain_valid", {159'd0, dreq.valid}, 160'd1);
      check_eq("post_drain_stall", {159'd0, stall}, 160'd0);

      // Reset while a request is outstanding.
      tick();
      dresp = '0;
      drive_op(1'b0, MSIZE4, 1'b0, 64'h8000_0040, 64'h0);
      #1;
      tick();
      in_valid = 1'b0;
      #1;
      check_eq("rw_wait_valid", {159'd0, dreq.valid}, 160'd1);
      tick();
      reset = 1'b1;
      #1;
      tick();
      reset = 1'b0;
      #1;
      check_eq("rw_dreq_valid", {159'd0, dreq.valid}, 160'd0);
      check_eq("rw_stall", {159'd0, stall}, 160'd0);
      check_eq("rw_out_valid", {159'd0, out_valid}, 160'd0);
      check_eq("rw_out_misalign", {159'd0, out_misalign}, 160'd0);

      tick();
      check_eq("sb_drained", sb_q.size(), 160'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
